rw_burst_sequencer: RTL and testbench

// - Generates the wr/rd command stream checked by the start->wr->rd protocol assertions.
// - A rising edge on start latches one command (addr, wdata).
// - The block then issues one write cycle followed by an RD_LEN-cycle read burst.
// - The reads target a small internal register file and return the data on rdata/rvalid.
// - Sits directly upstream of the protocol checker; the checker binds to start, wr and rd.

---
 rtl/rw_burst_sequencer.sv | 99 +++++++++
 tb/tb_rw_burst_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/rw_burst_sequencer.sv
// Command sequencer: a start rise latches (addr, wdata) and triggers one write,
// then an RD_LEN-cycle read burst from a small internal register file.
//
// state | meaning
// IDLE  | waiting for a start rise
// WRITE | single write cycle, commits wdata_l to mem[addr_l]
// READ  | RD_LEN read cycles from mem[addr_l + rcnt], address wraps
module rw_burst_sequencer #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int RD_LEN = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              wr,
  output logic              rd,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              busy,
  output logic              done,
  output logic              drop
);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(RD_LEN - 1);

  state_t            state;
  logic              start_q;
  logic              rise;
  logic [ADDR_W-1:0] addr_l;
  logic [DATA_W-1:0] wdata_l;
  logic [ADDR_W-1:0] rcnt;
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] mem [DEPTH];

  assign rise  = start & ~start_q;
  assign raddr = addr_l + rcnt;

  // start_q resets high so a start held through reset is not seen as a rise
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      start_q <= 1'b1;
      addr_l  <= '0;
      wdata_l <= '0;
      rcnt    <= '0;
      wr      <= 1'b0;
      rd      <= 1'b0;
      rdata   <= '0;
      rvalid  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      drop    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      start_q <= start;
      done    <= 1'b0;
      rvalid  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rise) begin
            addr_l  <= addr;
            wdata_l <= wdata;
            rcnt    <= '0;
            wr      <= 1'b1;
            busy    <= 1'b1;
            state   <= WRITE;
          end
        end
        WRITE: begin
          mem[addr_l] <= wdata_l;
          wr          <= 1'b0;
          rd          <= 1'b1;
          state       <= READ;
          if (rise) drop <= 1'b1;
        end
        READ: begin
          rdata  <= mem[raddr];
          rvalid <= 1'b1;
          rcnt   <= rcnt + 1'b1;
          if (rise) drop <= 1'b1;
          if (rcnt == LAST) begin
            rd    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rw_burst_sequencer.sv
// Scoreboard bench for rw_burst_sequencer: expected read data is queued when a
// command is issued and compared as rvalid beats come out.
module tb_rw_burst_sequencer;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int RD_LEN = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              wr, rd, rvalid, busy, done, drop;
  logic [DATA_W-1:0] rdata;

  int n_checks = 0;
  int n_pass   = 0;
  int wr_count = 0;
  int done_count = 0;
  int exp_cmds = 0;
  int exp_done = 0;

  logic [DATA_W-1:0] sb_q [$];
  logic [DATA_W-1:0] model_mem [2**ADDR_W];

  rw_burst_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LEN(RD_LEN)) dut (
    .clk(clk), .rst(rst), .start(start), .addr(addr), .wdata(wdata),
    .wr(wr), .rd(rd), .rdata(rdata), .rvalid(rvalid), .busy(busy),
    .done(done), .drop(drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 2**ADDR_W; i++) model_mem[i] = '0;
    sb_q.delete();
  endtask

  // called at a negedge with the DUT idle; returns at the negedge after the rise edge
  task automatic issue(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    start = 1'b1;
    addr  = a;
    wdata = d;
    model_mem[a] = d;
    for (int i = 0; i < RD_LEN; i++) sb_q.push_back(model_mem[ADDR_W'(a + i)]);
    exp_cmds++;
    exp_done++;
    @(negedge clk);
    start = 1'b0;
    addr  = ADDR_W'($urandom);
    wdata = DATA_W'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", done, 1);
  endtask

  // Monitor: scoreboard pops, wr/rd exclusivity and wr ##1 rd[*RD_LEN] shape
  int   run = 0;
  logic wr_prev = 1'b0;
  logic rst_e;
  always @(posedge clk) begin
    rst_e = rst;
    #1;
    if (rst_e) begin
      run = 0;
      wr_prev = 1'b0;
    end else begin
      if (wr || rd) chk("wr_rd_excl", wr && rd, 0);
      if (wr) wr_count++;
      if (done) done_count++;
      if (rvalid) begin
        if (sb_q.size() == 0) chk("sb_underflow", 1, 0);
        else chk("sb_rdata", rdata, sb_q.pop_front());
      end
      if (wr_prev) begin
        chk("shape_rd_first", rd, 1);
        run = 1;
      end else if (run > 0) begin
        if (run < RD_LEN) begin
          chk("shape_rd_run", rd, 1);
          run++;
        end else begin
          chk("shape_rd_end", rd, 0);
          run = 0;
        end
      end
      wr_prev = wr;
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; addr = '0; wdata = '0;
    clear_model();
    @(negedge clk);                       // 10ns
    chk("rst_wr", wr, 0);
    chk("rst_rd", rd, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_drop", drop, 0);
    chk("rst_rdata", rdata, 0);
    rst = 1'b0;
    @(negedge clk);                       // 20ns

    // Test 1: exact cycle timing, rise at 20ns
    issue(4'd3, 8'hA5);                   // returns at 30ns
    chk("t1_wr_35", wr, 1);
    chk("t1_busy_35", busy, 1);
    chk("t1_rd_35", rd, 0);
    @(negedge clk);                       // 40ns
    chk("t1_wr_45", wr, 0);
    chk("t1_rd_45", rd, 1);
    chk("t1_rvalid_45", rvalid, 0);
    @(negedge clk);                       // 50ns
    chk("t1_rd_55", rd, 1);
    chk("t1_rvalid_55", rvalid, 1);
    chk("t1_rdata_55", rdata, 8'hA5);
    @(negedge clk);                       // 60ns
    chk("t1_rd_65", rd, 0);
    chk("t1_done_65", done, 1);
    chk("t1_rvalid_65", rvalid, 1);
    chk("t1_rdata_65", rdata, 8'h00);
    chk("t1_busy_65", busy, 0);
    @(negedge clk);                       // 70ns
    chk("t1_done_75", done, 0);
    chk("t1_rvalid_75", rvalid, 0);

    // Test 2: address wrap, then a back-to-back command in the done cycle
    issue(4'd15, 8'h3C);
    wait_done();
    chk("t2_drop", drop, 0);
    issue(4'd2, 8'h77);
    wait_done();
    chk("t2_b2b_drop", drop, 0);
    @(negedge clk);

    // Test 3: rise during READ is dropped; burst completes
    issue(4'd5, 8'h11);                   // now in WRITE
    @(negedge clk);                       // now in READ
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    chk("t3_drop", drop, 1);
    repeat (3) @(negedge clk);
    chk("t3_drop_sticky", drop, 1);
    chk("t3_wr_count", wr_count, exp_cmds);

    // Test 4: start held high across reset release
    start = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_model();
    repeat (3) @(negedge clk);
    chk("t4_busy", busy, 0);
    chk("t4_drop_clr", drop, 0);
    chk("t4_no_cmd", wr_count, exp_cmds);
    start = 1'b0;
    @(negedge clk);
    issue(4'd9, 8'hE1);
    wait_done();
    chk("t4_one_cmd", wr_count, exp_cmds);

    // Test 5: reset during the first read cycle aborts and clears memory
    @(negedge clk);
    issue(4'd7, 8'h5A);                   // in WRITE
    @(negedge clk);                       // first rd cycle
    chk("t5_rd_before", rd, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_rd", rd, 0);
    chk("t5_busy", busy, 0);
    chk("t5_rvalid", rvalid, 0);
    chk("t5_wr", wr, 0);
    clear_model();
    exp_done--;
    repeat (4) @(negedge clk);
    chk("t5_no_done", done_count, exp_done);
    issue(4'd6, 8'hC3);                   // second read returns mem[7], expected cleared
    wait_done();

    repeat (3) @(negedge clk);
    chk("end_sb_empty", sb_q.size(), 0);
    chk("end_wr_count", wr_count, exp_cmds);
    chk("end_done_count", done_count, exp_done);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
